// File: rtl/grid_pkg.sv
// Shared constants and width helpers for the cell-grid VGA renderer.
package grid_pkg;

    localparam int unsigned RENDER_LATENCY = 3;
    localparam int unsigned DEF_COLOR_W    = 10;

    localparam logic [3*DEF_COLOR_W-1:0] DEF_ALIVE_RGB  = '1;
    localparam logic [3*DEF_COLOR_W-1:0] DEF_DEAD_RGB   = '0;
    localparam logic [3*DEF_COLOR_W-1:0] DEF_GRID_RGB   = {3{2'b01, 8'h00}};
    localparam logic [3*DEF_COLOR_W-1:0] DEF_CURSOR_RGB = {10'h3ff, 20'h0};
    localparam logic [3*DEF_COLOR_W-1:0] DEF_BORDER_RGB = '0;

    // Index width for n distinct values, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/grid_coord_split.sv
// Splits a pixel coordinate into cell index (quotient) and offset within the cell.
module grid_coord_split
    import grid_pkg::*;
#(
    parameter int unsigned COORD_W = 10,
    parameter int unsigned CELL_PX = 10,
    parameter int unsigned N       = 10
) (
    input  logic [COORD_W-1:0]          v,
    output logic [N-1:0]                q,
    output logic [idx_w(CELL_PX)-1:0]   m
);

    localparam int unsigned SUB_W = idx_w(CELL_PX);

    assign q = N'(32'(v) / CELL_PX);
    assign m = SUB_W'(32'(v) % CELL_PX);

endmodule

// File: rtl/grid_renderer.sv
// Three-stage pixel pipeline that paints a frame-synchronous snapshot of the
// life-engine cell array, with border, grid lines and a cursor outline.
module grid_renderer
    import grid_pkg::*;
#(
    parameter int unsigned COLS    = 64,
    parameter int unsigned ROWS    = 48,
    parameter int unsigned CELL_PX = 10,
    parameter int unsigned COORD_W = 10,
    parameter int unsigned COLOR_W = 10,
    parameter logic [3*COLOR_W-1:0] ALIVE_RGB  = '1,
    parameter logic [3*COLOR_W-1:0] DEAD_RGB   = '0,
    parameter logic [3*COLOR_W-1:0] GRID_RGB   = {3{2'b01, {(COLOR_W-2){1'b0}}}},
    parameter logic [3*COLOR_W-1:0] CURSOR_RGB = {{COLOR_W{1'b1}}, {(2*COLOR_W){1'b0}}},
    parameter logic [3*COLOR_W-1:0] BORDER_RGB = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [0:COLS*ROWS-1]       cells,
    input  logic                       frame_start,
    input  logic [COORD_W-1:0]         x,
    input  logic [COORD_W-1:0]         y,
    input  logic                       de_in,
    input  logic                       hsync_in,
    input  logic                       vsync_in,
    input  logic                       grid_en,
    input  logic                       cursor_en,
    input  logic [idx_w(COLS)-1:0]     cursor_col,
    input  logic [idx_w(ROWS)-1:0]     cursor_row,
    output logic [COLOR_W-1:0]         r,
    output logic [COLOR_W-1:0]         g,
    output logic [COLOR_W-1:0]         b,
    output logic                       de_out,
    output logic                       hsync_out,
    output logic                       vsync_out
);

    localparam int unsigned NCELL  = COLS * ROWS;
    localparam int unsigned IDX_W  = idx_w(NCELL);
    localparam int unsigned CC_W   = idx_w(COLS);
    localparam int unsigned CR_W   = idx_w(ROWS);
    localparam int unsigned SUB_W  = idx_w(CELL_PX);
    localparam int unsigned GRID_X = COLS * CELL_PX;
    localparam int unsigned GRID_Y = ROWS * CELL_PX;

    logic [0:NCELL-1]    snap;

    logic [COORD_W-1:0]  col_c, row_c;
    logic [SUB_W-1:0]    subx_c, suby_c;
    logic                in_grid_c;
    logic [IDX_W-1:0]    idx_c;
    logic                alive_c;

    logic [COORD_W-1:0]  s1_col, s1_row;
    logic [SUB_W-1:0]    s1_subx, s1_suby;
    logic                s1_in_grid, s1_alive, s1_de, s1_hs, s1_vs;
    logic                s1_grid_en, s1_cursor_en;
    logic [CC_W-1:0]     s1_ccol;
    logic [CR_W-1:0]     s1_crow;

    logic                grid_hit_c, edge_c, cur_ok_c, cursor_hit_c;
    logic                s2_alive, s2_grid, s2_cursor, s2_de, s2_in_grid, s2_hs, s2_vs;

    logic [3*COLOR_W-1:0] colour_c;

    grid_coord_split #(.COORD_W(COORD_W), .CELL_PX(CELL_PX), .N(COORD_W)) u_split_x (
        .v (x),
        .q (col_c),
        .m (subx_c)
    );

    grid_coord_split #(.COORD_W(COORD_W), .CELL_PX(CELL_PX), .N(COORD_W)) u_split_y (
        .v (y),
        .q (row_c),
        .m (suby_c)
    );

    // The cell bit is read on the same edge that may reload the snapshot, so a
    // pixel presented alongside frame_start still sees the previous frame.
    always_comb begin
        in_grid_c = (32'(x) < GRID_X) && (32'(y) < GRID_Y);
        idx_c     = '0;
        if (in_grid_c) begin
            idx_c = IDX_W'(row_c) * IDX_W'(COLS) + IDX_W'(col_c);
        end
        alive_c = in_grid_c && snap[idx_c];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            snap <= '0;
        end else if (frame_start) begin
            snap <= cells;
        end
    end

    always_comb begin
        grid_hit_c   = s1_grid_en && (s1_subx == '0 || s1_suby == '0);
        edge_c       = (s1_subx == '0) || (s1_subx == SUB_W'(CELL_PX - 1)) ||
                       (s1_suby == '0) || (s1_suby == SUB_W'(CELL_PX - 1));
        cur_ok_c     = (32'(s1_ccol) < COLS) && (32'(s1_crow) < ROWS);
        cursor_hit_c = s1_cursor_en && cur_ok_c && edge_c &&
                       (s1_col == COORD_W'(s1_ccol)) && (s1_row == COORD_W'(s1_crow));
    end

    // First match wins: blanking, border, cursor, grid, cell state.
    always_comb begin
        colour_c = DEAD_RGB;
        if (!s2_de) begin
            colour_c = '0;
        end else if (!s2_in_grid) begin
            colour_c = BORDER_RGB;
        end else if (s2_cursor) begin
            colour_c = CURSOR_RGB;
        end else if (s2_grid) begin
            colour_c = GRID_RGB;
        end else if (s2_alive) begin
            colour_c = ALIVE_RGB;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_col       <= '0;
            s1_row       <= '0;
            s1_subx      <= '0;
            s1_suby      <= '0;
            s1_in_grid   <= 1'b0;
            s1_alive     <= 1'b0;
            s1_de        <= 1'b0;
            s1_hs        <= 1'b0;
            s1_vs        <= 1'b0;
            s1_grid_en   <= 1'b0;
            s1_cursor_en <= 1'b0;
            s1_ccol      <= '0;
            s1_crow      <= '0;
            s2_alive     <= 1'b0;
            s2_grid      <= 1'b0;
            s2_cursor    <= 1'b0;
            s2_de        <= 1'b0;
            s2_in_grid   <= 1'b0;
            s2_hs        <= 1'b0;
            s2_vs        <= 1'b0;
            r            <= '0;
            g            <= '0;
            b            <= '0;
            de_out       <= 1'b0;
            hsync_out    <= 1'b0;
            vsync_out    <= 1'b0;
        end else begin
            s1_col       <= col_c;
            s1_row       <= row_c;
            s1_subx      <= subx_c;
            s1_suby      <= suby_c;
            s1_in_grid   <= in_grid_c;
            s1_alive     <= alive_c;
            s1_de        <= de_in;
            s1_hs        <= hsync_in;
            s1_vs        <= vsync_in;
            s1_grid_en   <= grid_en;
            s1_cursor_en <= cursor_en;
            s1_ccol      <= cursor_col;
            s1_crow      <= cursor_row;

            s2_alive     <= s1_alive;
            s2_grid      <= grid_hit_c;
            s2_cursor    <= cursor_hit_c;
            s2_de        <= s1_de;
            s2_in_grid   <= s1_in_grid;
            s2_hs        <= s1_hs;
            s2_vs        <= s1_vs;

            r            <= colour_c[3*COLOR_W-1:2*COLOR_W];
            g            <= colour_c[2*COLOR_W-1:COLOR_W];
            b            <= colour_c[COLOR_W-1:0];
            de_out       <= s2_de;
            hsync_out    <= s2_hs;
            vsync_out    <= s2_vs;
        end
    end

endmodule
